i2c_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer sharing one I2C core between up to N_REQ requesters (accelerometer controller, future sensor/config controllers). Latches one requester's transaction, issues a single-cycle `data_valid` to the core, tracks `core_busy` to completion and returns a one-cycle `done`, read byte and error flag to that requester. Sits between the per-sensor controllers and the I2C core, replacing direct controller-to-core wiring.

---
 rtl/i2c_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C core between N_REQ requesters.
// Each transaction is granted round-robin. Its fields are latched onto the
// core-side outputs, and a one-cycle data_valid strobe starts the core. The
// arbiter then follows core_busy until the core finishes. Completion returns
// a one-cycle done pulse, the read byte and an error flag. err=1 means the
// core never went busy within BUSY_TIMEOUT cycles.
module i2c_arbiter #(
    parameter int N_REQ        = 2,
    parameter int BUSY_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,

    // requester side
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [7*N_REQ-1:0]   req_slave_addr,
    input  logic [8*N_REQ-1:0]   req_reg_addr,
    input  logic [8*N_REQ-1:0]   req_reg_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [7:0]           rd_data,

    // core side
    input  logic                 core_busy,
    input  logic [7:0]           core_rd_data,
    output logic                 data_valid,
    output logic                 rw,
    output logic [6:0]           slave_addr,
    output logic [7:0]           reg_addr,
    output logic [7:0]           reg_data
);

    // N_REQ is at least 2, so the index width is at least one bit.
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t            state;
    state_t            next_state;

    // Index of the last requester served. The search for the next winner
    // starts one past it.
    logic [PTR_W-1:0]  ptr;

    // Index of the requester that owns the transaction in flight.
    logic [PTR_W-1:0]  owner;

    // Cycles spent in WAIT_BUSY waiting for the core to accept the strobe.
    logic [CNT_W-1:0]  cnt;

    // Round-robin search results.
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;

    // Control strobes from the FSM to the datapath.
    logic              latch_en;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              timeout_hit;
    logic              busy_done;

    // Pick the first requesting index after ptr, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop. Without it
        // some paths leave it unassigned, and synthesis infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = PTR_W'((int'(ptr) + off) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register; an asynchronous reset returns the sequencer to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together at the edge, whatever order the blocks run in.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic with the per-state strobes and outputs.
    always_comb begin
        next_state  = state;
        latch_en    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_hit = 1'b0;
        busy_done   = 1'b0;
        data_valid  = 1'b0;
        done        = '0;

        case (state)
            IDLE: begin
                // The core must be free before a new transaction is latched.
                if (win_found && !core_busy) begin
                    latch_en   = 1'b1;
                    next_state = ISSUE;
                end
            end

            ISSUE: begin
                data_valid = 1'b1;
                cnt_clr    = 1'b1;
                next_state = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                // Busy seen on the final counted cycle still counts as success.
                if (core_busy) begin
                    next_state = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = COMPLETE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            WAIT_DONE: begin
                // Once the core has started, the arbiter waits for it without
                // a time limit.
                if (!core_busy) begin
                    busy_done  = 1'b1;
                    next_state = COMPLETE;
                end
            end

            COMPLETE: begin
                done       = grant;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's fields and grant, and keep them until the next latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw         <= 1'b0;
            slave_addr <= '0;
            reg_addr   <= '0;
            reg_data   <= '0;
            owner      <= '0;
            grant      <= '0;
        end else if (latch_en) begin
            owner <= win_idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (win_idx == PTR_W'(i)) begin
                    rw         <= req_rw[i];
                    slave_addr <= req_slave_addr[7*i +: 7];
                    reg_addr   <= req_reg_addr[8*i +: 8];
                    reg_data   <= req_reg_data[8*i +: 8];
                    grant      <= N_REQ'(1) << i;
                end
            end
        end else if (state == COMPLETE) begin
            // The address and data fields stay on the core bus; only the
            // grant is released.
            grant <= '0;
        end
    end

    // After each completion, move the round-robin pointer to the requester
    // just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= PTR_RESET;
        end else if (state == COMPLETE) begin
            ptr <= owner;
        end
    end

    // Count the cycles spent waiting for core_busy after the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Record the result: the error flag, and the read byte for reads only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            rd_data <= '0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end else if (busy_done) begin
            err <= 1'b0;
            if (rw) begin
                rd_data <= core_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed scenarios for i2c_arbiter with two requesters and
// a short busy timeout. The bench itself plays the role of the I2C core.
module tb_i2c_arbiter;

    localparam int N_REQ        = 2;
    localparam int BUSY_TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     req_rw;
    logic [7*N_REQ-1:0]   req_slave_addr;
    logic [8*N_REQ-1:0]   req_reg_addr;
    logic [8*N_REQ-1:0]   req_reg_data;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic                 err;
    logic [7:0]           rd_data;
    logic                 core_busy;
    logic [7:0]           core_rd_data;
    logic                 data_valid;
    logic                 rw;
    logic [6:0]           slave_addr;
    logic [7:0]           reg_addr;
    logic [7:0]           reg_data;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_arbiter #(
        .N_REQ        (N_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_rw         (req_rw),
        .req_slave_addr (req_slave_addr),
        .req_reg_addr   (req_reg_addr),
        .req_reg_data   (req_reg_data),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .rd_data        (rd_data),
        .core_busy      (core_busy),
        .core_rd_data   (core_rd_data),
        .data_valid     (data_valid),
        .rw             (rw),
        .slave_addr     (slave_addr),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Advance one clock edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until data_valid is seen, or until the limit runs out.
    task automatic wait_strobe(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            tick();
            cycles++;
            if (data_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        req          = '0;
        req_rw       = '0;
        req_slave_addr = '0;
        req_reg_addr = '0;
        req_reg_data = '0;
        core_busy    = 1'b0;
        core_rd_data = '0;
        repeat (2) tick();
        req = 2'b01;
        tick();
        n_checks++;
        if ({grant, done, data_valid, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b done=%b dv=%b err=%b, want all 0",
                     grant, done, data_valid, err);
        end
        n_checks++;
        if ({rw, slave_addr, reg_addr, reg_data, rd_data} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got rw=%b sa=%h ra=%h rd=%h rdata=%h, want 0",
                     rw, slave_addr, reg_addr, reg_data, rd_data);
        end
        req = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        req_rw[0]            = 1'b0;
        req_slave_addr[6:0]  = 7'h1D;
        req_reg_addr[7:0]    = 8'h2D;
        req_reg_data[7:0]    = 8'h08;
        req                  = 2'b01;
        tick();                                    // strobe cycle
        n_checks++;
        if (data_valid !== 1'b1 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL write_strobe: got dv=%b grant=%b, want dv=1 grant=01", data_valid, grant);
        end
        n_checks++;
        if ({rw, slave_addr, reg_addr, reg_data} !== {1'b0, 7'h1D, 8'h2D, 8'h08}) begin
            n_fail++;
            $display("FAIL write_fields: got rw=%b sa=%h ra=%h rd=%h, want 0/1d/2d/08",
                     rw, slave_addr, reg_addr, reg_data);
        end
        tick();
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_strobe_width: got dv=%b one cycle after strobe, want 0", data_valid);
        end
        tick();
        tick();
        core_busy = 1'b1;                          // busy 3 cycles after strobe
        repeat (20) tick();
        core_busy = 1'b0;
        tick();
        n_checks++;
        if (done !== 2'b01 || err !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL write_done: got done=%b err=%b rd_data=%h, want 01/0/00", done, err, rd_data);
        end
        req = '0;
        tick();
        n_checks++;
        if (done !== 2'b00 || grant !== 2'b00 || slave_addr !== 7'h1D) begin
            n_fail++;
            $display("FAIL write_after: got done=%b grant=%b sa=%h, want 00/00/1d", done, grant, slave_addr);
        end
    endtask

    task automatic test_single_read();
        req_rw[1]            = 1'b1;
        req_slave_addr[13:7] = 7'h1D;
        req_reg_addr[15:8]   = 8'h32;
        req_reg_data[15:8]   = 8'h00;
        req                  = 2'b10;
        tick();
        n_checks++;
        if (data_valid !== 1'b1 || grant !== 2'b10 || rw !== 1'b1 ||
            slave_addr !== 7'h1D || reg_addr !== 8'h32) begin
            n_fail++;
            $display("FAIL read_strobe: got dv=%b grant=%b rw=%b sa=%h ra=%h, want 1/10/1/1d/32",
                     data_valid, grant, rw, slave_addr, reg_addr);
        end
        tick();
        core_busy = 1'b1;
        repeat (5) tick();
        core_busy    = 1'b0;
        core_rd_data = 8'hA5;
        tick();
        n_checks++;
        if (done !== 2'b10 || err !== 1'b0 || rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_done: got done=%b err=%b rd_data=%h, want 10/0/a5", done, err, rd_data);
        end
        req          = '0;
        core_rd_data = 8'h00;
        repeat (4) tick();
        n_checks++;
        if (done !== 2'b00 || rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_hold: got done=%b rd_data=%h, want 00/a5", done, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0] core_b [4] = '{8'h77, 8'h3C, 8'h99, 8'hC3};
        logic [7:0] exp_rd [4] = '{8'hA5, 8'h3C, 8'h3C, 8'hC3};
        int cyc;
        bit seen;
        req_rw = 2'b10;
        req    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(4, cyc, seen);
            n_checks++;
            if (!seen || cyc != 1) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got seen=%0d cycles=%0d, want seen=1 cycles=1", k, seen, cyc);
            end
            n_checks++;
            if (grant !== exp_g[k]) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: got %b, want %b", k, grant, exp_g[k]);
            end
            tick();
            core_busy = 1'b1;
            tick();
            core_busy    = 1'b0;
            core_rd_data = core_b[k];
            tick();
            n_checks++;
            if (done !== exp_g[k] || rd_data !== exp_rd[k]) begin
                n_fail++;
                $display("FAIL b2b_done[%0d]: got done=%b rd_data=%h, want %b/%h",
                         k, done, rd_data, exp_g[k], exp_rd[k]);
            end
            tick();
            n_checks++;
            if (done !== 2'b00 || grant !== 2'b00 || data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got done=%b grant=%b dv=%b, want 00/00/0",
                         k, done, grant, data_valid);
            end
            if (k == 3) req = '0;
        end
    endtask

    task automatic test_timeout();
        req_slave_addr[6:0] = 7'h50;
        req                 = 2'b01;
        tick();
        n_checks++;
        if (data_valid !== 1'b1 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL to_strobe: got dv=%b grant=%b, want 1/01", data_valid, grant);
        end
        repeat (8) tick();
        n_checks++;
        if (done !== 2'b00) begin
            n_fail++;
            $display("FAIL to_early: got done=%b 8 cycles after strobe, want 00", done);
        end
        tick();
        n_checks++;
        if (done !== 2'b01 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_done: got done=%b err=%b 9 cycles after strobe, want 01/1", done, err);
        end
        req = '0;
        tick();
        // A normal transaction afterwards must clear err.
        req = 2'b01;
        tick();
        n_checks++;
        if (data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL to_recover_strobe: got dv=%b, want 1", data_valid);
        end
        tick();
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        n_checks++;
        if (done !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_recover_done: got done=%b err=%b, want 01/0", done, err);
        end
        req = '0;
        tick();
    endtask

    task automatic test_busy_hold();
        core_busy           = 1'b1;
        req_slave_addr[6:0] = 7'h22;
        req                 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (data_valid !== 1'b0 || grant !== 2'b00) begin
                n_fail++;
                $display("FAIL hold_wait[%0d]: got dv=%b grant=%b while core busy, want 0/00",
                         i, data_valid, grant);
            end
        end
        core_busy = 1'b0;
        tick();
        n_checks++;
        if (data_valid !== 1'b1 || grant !== 2'b01 || slave_addr !== 7'h22) begin
            n_fail++;
            $display("FAIL hold_strobe: got dv=%b grant=%b sa=%h, want 1/01/22",
                     data_valid, grant, slave_addr);
        end
        tick();
        core_busy = 1'b1;
        tick();
        core_busy    = 1'b0;
        core_rd_data = 8'h4E;
        tick();
        n_checks++;
        if (done !== 2'b01 || rd_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL hold_done: got done=%b rd_data=%h, want 01/c3", done, rd_data);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 2'b10;
        tick();
        tick();
        core_busy = 1'b1;
        tick();                                    // now in WAIT_DONE
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got grant=%b before reset, want 10", grant);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({grant, done, data_valid, err} !== 6'b0 ||
            {rw, slave_addr, reg_addr, reg_data, rd_data} !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got grant=%b done=%b dv=%b err=%b rw=%b sa=%h rd=%h, want 0",
                     grant, done, data_valid, err, rw, slave_addr, rd_data);
        end
        core_busy = 1'b0;
        req       = 2'b11;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (data_valid !== 1'b1 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_first_winner: got dv=%b grant=%b, want 1/01", data_valid, grant);
        end
        req = 2'b01;
        tick();
        core_busy = 1'b1;
        tick();
        core_busy = 1'b0;
        tick();
        n_checks++;
        if (done !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_done: got done=%b err=%b, want 01/0", done, err);
        end
        req = '0;
        tick();
    endtask

    // Stop the run if it does not finish within the time limit.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
